mn_addr_gen: RTL and testbench
==============================

Name: mn_addr_gen

Overview:
- Downstream consumer of one lane of the M/N index ripple counter.
- Takes each (M, N) index pair with its done pulse and last flag, and computes a linear SRAM address: base + M*row_stride + N.
- Buffers results in a FIFO, because the counter has no backpressure, and presents them to the memory read port over a valid/ready handshake.
- Flags a sticky overflow if results arrive while the FIFO is full.

Parameters:
- Width, 8, bit width of the M/N indices.
- AddrWidth, 16, bit width of base, stride and output address.
- FifoDepth, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of pipeline, FIFO and overflow flag
- idx_valid_i  in  1  index pair valid; driven by the counter lane's done pulse
- M_idx_i  in  Width  row index, unsigned
- N_idx_i  in  Width  column index, unsigned
- last_i  in  1  marks the final pair of the tile
- base_addr_i  in  AddrWidth  tile base address; quasi-static during a tile
- row_stride_i  in  AddrWidth  words per row; quasi-static during a tile
- addr_valid_o  out  1  FIFO head valid
- addr_ready_i  in  1  memory port accepts the head
- addr_o  out  AddrWidth  head address
- addr_last_o  out  1  head carries last_i
- busy_o  out  1  pipeline or FIFO non-empty
- overflow_o  out  1  sticky: a result was dropped

Behaviour:
- Reset (async, rst_ni low): all pipeline valids, FIFO pointers and count, and overflow_o go to 0. Outputs then read addr_valid_o=0, addr_o=0, addr_last_o=0, busy_o=0, overflow_o=0. Reset mid-operation discards all in-flight and buffered entries.
- Stage 1 (edge after idx_valid_i):
  - Register N_idx, last and valid.
  - Register prod = M_idx * row_stride_i, truncated to AddrWidth.
- Stage 2 (next edge):
  - sum = base_addr_i + prod + zero-extended N_idx, modulo 2^AddrWidth; no saturation.
  - Push {sum, last} into the FIFO.
- Latency: a pair sampled at edge k becomes visible at the FIFO head (addr_valid_o=1) after edge k+2 when the FIFO was empty.
- Throughput: one pair per cycle; back-to-back idx_valid_i is legal.
- Handshake:
  - Pop occurs on an edge with addr_valid_o & addr_ready_i.
  - addr_o and addr_last_o hold stable while addr_valid_o=1 and addr_ready_i=0.
  - addr_ready_i while empty is ignored.
- FIFO full:
  - A stage-2 push with count==FifoDepth and no simultaneous pop is dropped, and overflow_o is set.
  - A push and a pop in the same cycle while full are both performed; count is unchanged and nothing is dropped.
- FIFO empty: a push and pop cannot coincide. The head is registered, so there is no combinational pass-through.
- overflow_o stays 1 until clear_i or reset.
- clear_i: on the next edge, pipeline valids, pointers and overflow_o are cleared.
  - clear_i has priority over an idx_valid_i or push in the same cycle; those are discarded.
  - A pop in the same cycle is also discarded.
- busy_o = s1_valid | s2_valid | (count != 0).
- Pointer wrap: pointers are log2(FifoDepth) bits and wrap naturally. count has log2(FifoDepth)+1 bits.
- base_addr_i and row_stride_i are sampled per stage. Changing them mid-tile is illegal; the result is undefined but must not corrupt the FIFO state.

Decomposition:
- Package mn_addr_pkg:
  - addr_entry_t struct {addr, last}.
  - Default width localparams.
- One sub-module: mn_addr_fifo, a synchronous FIFO.
  - Parameterised depth and entry type.
  - Push/pop ports with full/empty/count.
  - Async active-low reset and sync clear.
- The two-stage arithmetic pipeline stays in the top module.

Test Plan:
- Single pair, base=0x100, stride=8, M=3, N=5, addr_ready_i=1 → addr_valid_o high exactly one cycle, at edge k+2; addr_o=0x11D; addr_last_o=0.
- Full 2x3 tile: pairs (0,0)..(1,2) back-to-back, base=0, stride=3, last on (1,2), ready=1 → addresses 0,1,2,3,4,5 in order; last only on 5; busy_o low 3 cycles after the final input.
- Backpressure: ready=0, 4 pairs pushed (FifoDepth=4) → count=4, overflow_o=0, head stable. A 5th pair → overflow_o=1 and the 5th is dropped. Then ready=1 → exactly 4 addresses drain.
- Full with simultaneous push/pop: FIFO full, ready=1 on the cycle a new result reaches stage 2 → no drop; overflow_o=0; ordering preserved.
- Wrap-around arithmetic: AddrWidth=16, base=0xFFF0, stride=0x10, M=1, N=0x20 → addr_o=0x0020.
- Clear and reset: clear_i while 2 entries are buffered and 1 is in flight → next cycle busy_o=0, addr_valid_o=0, overflow_o=0. rst_ni pulsed low asynchronously mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/mn_addr_pkg.sv
// Shared defaults and payload type for the M/N address generator.
package mn_addr_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefFifoDepth = 4;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic                    last;
    } addr_entry_t;

endpackage

// File: rtl/mn_addr_fifo.sv
// Synchronous FIFO with registered storage, async reset and sync clear.
module mn_addr_fifo #(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees a slot the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mn_addr_gen.sv
// Converts M/N index pairs into linear SRAM addresses (base + M*stride + N),
// buffered in a FIFO and presented over a valid/ready port.
module mn_addr_gen
    import mn_addr_pkg::*;
#(
    parameter int unsigned Width     = DefWidth,
    parameter int unsigned AddrWidth = DefAddrWidth,
    parameter int unsigned FifoDepth = DefFifoDepth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 idx_valid_i,
    input  logic [Width-1:0]     M_idx_i,
    input  logic [Width-1:0]     N_idx_i,
    input  logic                 last_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] row_stride_i,
    output logic                 addr_valid_o,
    input  logic                 addr_ready_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 addr_last_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 last;
    } entry_t;

    logic                 s1_valid_q, s1_valid_d;
    logic [Width-1:0]     s1_n_q, s1_n_d;
    logic                 s1_last_q, s1_last_d;
    logic [AddrWidth-1:0] s1_prod_q, s1_prod_d;
    logic                 s2_valid_q, s2_valid_d;
    entry_t               s2_entry_q, s2_entry_d;
    logic                 overflow_q, overflow_d;

    entry_t               head;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [CntW-1:0]      fifo_count;

    assign fifo_pop = addr_valid_o & addr_ready_i;

    // Two-stage arithmetic: multiply in stage 1, add base and column in stage 2.
    always_comb begin
        s1_valid_d = idx_valid_i;
        s1_n_d     = s1_n_q;
        s1_last_d  = s1_last_q;
        s1_prod_d  = s1_prod_q;
        s2_valid_d = s1_valid_q;
        s2_entry_d = s2_entry_q;
        overflow_d = overflow_q | (s2_valid_q & fifo_full & ~fifo_pop);
        if (idx_valid_i) begin
            s1_n_d    = N_idx_i;
            s1_last_d = last_i;
            s1_prod_d = AddrWidth'(AddrWidth'(M_idx_i) * row_stride_i);
        end
        if (s1_valid_q) begin
            s2_entry_d.addr = base_addr_i + s1_prod_q + AddrWidth'(s1_n_q);
            s2_entry_d.last = s1_last_q;
        end
        if (clear_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_n_q     <= '0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_entry_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_n_q     <= s1_n_d;
            s1_last_q  <= s1_last_d;
            s1_prod_q  <= s1_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_entry_q <= s2_entry_d;
            overflow_q <= overflow_d;
        end
    end

    mn_addr_fifo #(
        .Depth   (FifoDepth),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (s2_valid_q),
        .data_i  (s2_entry_q),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head fields read as zero when nothing is buffered.
    assign addr_valid_o = ~fifo_empty;
    assign addr_o       = fifo_empty ? '0 : head.addr;
    assign addr_last_o  = ~fifo_empty & head.last;
    assign busy_o       = s1_valid_q | s2_valid_q | (fifo_count != '0);
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mn_addr_gen.sv
// Randomised scoreboard bench for mn_addr_gen against a queue-based reference model.
module tb_mn_addr_gen;
    import mn_addr_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned D  = 4;

    logic          clk, rst_n, clear_i, idx_valid_i, last_i, addr_ready_i;
    logic [W-1:0]  m_idx, n_idx;
    logic [AW-1:0] base_addr, row_stride, addr_o;
    logic          addr_valid_o, addr_last_o, busy_o, overflow_o;

    mn_addr_gen #(.Width(W), .AddrWidth(AW), .FifoDepth(D)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear_i),
        .idx_valid_i  (idx_valid_i),
        .M_idx_i      (m_idx),
        .N_idx_i      (n_idx),
        .last_i       (last_i),
        .base_addr_i  (base_addr),
        .row_stride_i (row_stride),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .addr_o       (addr_o),
        .addr_last_o  (addr_last_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        addr_entry_t e;
        int          due;
    } pend_t;

    pend_t       pend[$];
    addr_entry_t sb[$];
    bit          exp_ovf;
    int          cyc;
    int          vectors;
    int          miscompares;

    // Model scratch, used only by the model process.
    bit          m_pop;
    int          m_n;
    pend_t       m_arr, m_new;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each pair lands in an ideal queue two edges after it is sampled,
    // unless the queue is full and not being drained that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            sb.delete();
            exp_ovf = 1'b0;
        end else begin
            cyc++;
            if (clear_i) begin
                pend.delete();
                sb.delete();
                exp_ovf = 1'b0;
            end else begin
                m_n   = sb.size();
                m_pop = (m_n != 0) && addr_ready_i;
                if (m_pop) void'(sb.pop_front());
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    m_arr = pend.pop_front();
                    if (m_n == int'(D) && !m_pop) exp_ovf = 1'b1;
                    else sb.push_back(m_arr.e);
                end
                if (idx_valid_i) begin
                    m_new.e.addr = AW'(32'(base_addr) + 32'(m_idx) * 32'(row_stride) + 32'(n_idx));
                    m_new.e.last = last_i;
                    m_new.due    = cyc + 2;
                    pend.push_back(m_new);
                end
            end
        end
    end

    // Monitor: compare the DUT's presented head and status against the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("addr_valid", 32'(addr_valid_o), 32'(sb.size() != 0));
            if (sb.size() != 0 && addr_valid_o) begin
                check("addr", 32'(addr_o), 32'(sb[0].addr));
                check("addr_last", 32'(addr_last_o), 32'(sb[0].last));
            end
            check("busy", 32'(busy_o), 32'((pend.size() != 0) || (sb.size() != 0)));
            check("overflow", 32'(overflow_o), 32'(exp_ovf));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input int n, input bit l);
        idx_valid_i = 1'b1;
        m_idx       = W'(m);
        n_idx       = W'(n);
        last_i      = l;
        step();
        idx_valid_i = 1'b0;
        last_i      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(addr_valid_o), 0);
        check({tag, "_addr"}, 32'(addr_o), 0);
        check({tag, "_last"}, 32'(addr_last_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_ovf"}, 32'(overflow_o), 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; exp_ovf = 1'b0;
        rst_n = 1'b0; clear_i = 1'b0; idx_valid_i = 1'b0; last_i = 1'b0;
        addr_ready_i = 1'b0; m_idx = '0; n_idx = '0; base_addr = '0; row_stride = '0;
        #3;
        check_all_zero("reset");
        step(2);
        rst_n = 1'b1;
        step(2);

        // Single pair: 0x100 + 3*8 + 5 = 0x11D.
        addr_ready_i = 1'b1; base_addr = 16'h0100; row_stride = 16'd8;
        send(3, 5, 1'b0);
        step(5);

        // 2x3 tile with stride 3: addresses 0..5, last on the final pair.
        base_addr = '0; row_stride = 16'd3;
        for (int m = 0; m < 2; m++)
            for (int n = 0; n < 3; n++)
                send(m, n, (m == 1) && (n == 2));
        step(5);

        // Backpressure: fill the FIFO, drop a fifth pair, then drain.
        addr_ready_i = 1'b0; base_addr = 16'h0040; row_stride = 16'd2;
        for (int i = 0; i < 4; i++) send(i, i, 1'b0);
        step(3);
        send(7, 7, 1'b1);
        step(3);
        addr_ready_i = 1'b1;
        step(8);
        clear_i = 1'b1; step(); clear_i = 1'b0;

        // Full FIFO with a push and pop landing on the same edge.
        addr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(1, i, 1'b0);
        step(2);
        send(2, 9, 1'b1);
        step();
        addr_ready_i = 1'b1;
        step(8);

        // Address wrap modulo 2^16.
        base_addr = 16'hFFF0; row_stride = 16'h0010;
        send(1, 8'h20, 1'b0);
        step(2);
        check("wrap_addr", 32'(addr_o), 32'h0020);
        step(4);

        // Clear with two entries buffered and one in flight.
        addr_ready_i = 1'b0; base_addr = 16'h0200; row_stride = 16'h0004;
        send(0, 1, 1'b0);
        send(0, 2, 1'b0);
        step(2);
        send(0, 3, 1'b0);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        check("clear_busy", 32'(busy_o), 0);
        check("clear_valid", 32'(addr_valid_o), 0);
        check("clear_ovf", 32'(overflow_o), 0);
        step(3);

        // Randomised bursts; base and stride change only while idle.
        for (int b = 0; b < 40; b++) begin
            int rdy_pct;
            base_addr  = AW'($urandom);
            row_stride = AW'($urandom_range(0, 1023));
            rdy_pct    = int'($urandom_range(10, 100));
            for (int c = 0; c < 60; c++) begin
                idx_valid_i  = ($urandom_range(0, 99) < 60);
                m_idx        = W'($urandom);
                n_idx        = W'($urandom);
                last_i       = ($urandom_range(0, 7) == 0);
                addr_ready_i = (int'($urandom_range(0, 99)) < rdy_pct);
                clear_i      = ($urandom_range(0, 199) == 0);
                step();
            end
            idx_valid_i = 1'b0; last_i = 1'b0; clear_i = 1'b0; addr_ready_i = 1'b1;
            step(12);
            if ($urandom_range(0, 3) == 0) begin
                clear_i = 1'b1; step(); clear_i = 1'b0;
            end
        end

        // Asynchronous reset in the middle of traffic.
        addr_ready_i = 1'b0; base_addr = 16'h0010; row_stride = 16'h0001;
        for (int i = 0; i < 3; i++) send(i, i, 1'b0);
        idx_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        idx_valid_i = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
